// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported RAM between instruction fetch and data, data first.
// Define MEM_ARB_STARVE_EN to force an instruction grant after STARVE_LIMIT back-to-back data grants.
module mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              ihit,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dhit,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023 || STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_param
        $error("mem_arbiter: parameter out of range");
    end

    state_t     r_state, w_next, w_pick;
    logic [9:0] r_wait;
    logic       r_err;
    logic       w_dreq, w_req, w_grant, w_acc, w_to, w_fail;

    assign w_dreq  = dREN | dWEN;
    assign w_grant = r_state != IDLE;
    assign w_req   = (r_state == DGRANT) ? w_dreq : iREN;
    assign w_acc   = ramstate == 2'd2;
    // Abort on the grant cycle that would bring the wait count up to the limit.
    assign w_to    = w_grant && !w_acc && r_wait == 10'(TIMEOUT_CYCLES - 1);
    assign w_fail  = w_grant && (ramstate == 2'd3 || w_to);

`ifdef MEM_ARB_STARVE_EN
    logic [2:0] r_starve;
    logic       w_force;
    assign w_force = iREN && r_starve == 3'(STARVE_LIMIT);
    assign w_pick  = w_force ? IGRANT : w_dreq ? DGRANT : iREN ? IGRANT : IDLE;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_starve <= '0;
        else if (r_state == IDLE) r_starve <= (!iREN || w_force || !w_dreq) ? '0 : r_starve + 3'd1;
    end
`else
    assign w_pick = w_dreq ? DGRANT : iREN ? IGRANT : IDLE;
`endif

    always_comb begin
        w_next = (r_state == IDLE) ? w_pick : (!w_req || w_acc || w_fail) ? IDLE : r_state;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_wait  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wait  <= (w_grant && w_next != IDLE) ? r_wait + 10'd1 : '0;
            r_err   <= r_err | w_fail;
        end
    end

    assign ramREN   = (r_state == DGRANT) ? dREN & ~dWEN : (r_state == IGRANT) & iREN;
    assign ramWEN   = (r_state == DGRANT) & dWEN;
    assign ramaddr  = (r_state == DGRANT) ? daddr : (r_state == IGRANT) ? iaddr : '0;
    assign ramstore = (r_state == DGRANT) ? dstore : '0;
    assign dhit     = (r_state == DGRANT) & w_dreq & w_acc;
    assign ihit     = (r_state == IGRANT) & iREN & w_acc;
    assign dload    = dhit ? ramload : '0;
    assign iload    = ihit ? ramload : '0;
    assign err      = r_err;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus checked every cycle against a grant-owner model plus literal pins.
module tb_mem_arbiter;
    localparam int TMO = 8;
    localparam int SL  = 4;

    logic        CLK, RST;
    logic        iREN, dREN, dWEN, ihit, dhit, ramREN, ramWEN, err;
    logic [31:0] iaddr, daddr, dstore, iload, dload, ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO), .STARVE_LIMIT(SL)) dut (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dhit(dhit), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err(err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Model: who currently owns the RAM (0 none, 1 data, 2 instruction) and how long it has waited.
    int   own, waited;
    logic m_err;
`ifdef MEM_ARB_STARVE_EN
    int   starve;
`endif
    logic m_dreq, m_req;
    assign m_dreq = dREN | dWEN;
    assign m_req  = (own == 1) ? m_dreq : (own == 2) ? iREN : 1'b0;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            own <= 0; waited <= 0; m_err <= 1'b0;
`ifdef MEM_ARB_STARVE_EN
            starve <= 0;
`endif
        end else if (own == 0) begin
`ifdef MEM_ARB_STARVE_EN
            own    <= (iREN && starve == SL) ? 2 : m_dreq ? 1 : iREN ? 2 : 0;
            starve <= (!iREN || starve == SL || !m_dreq) ? 0 : starve + 1;
`else
            own    <= m_dreq ? 1 : iREN ? 2 : 0;
`endif
        end else begin
            if (ramstate == 2'd3 || (ramstate != 2'd2 && waited + 1 == TMO)) m_err <= 1'b1;
            if (!m_req || ramstate == 2'd2 || ramstate == 2'd3 || waited + 1 == TMO) begin
                own <= 0; waited <= 0;
            end else waited <= waited + 1;
        end
    end

    logic [31:0] act [1:9];
    logic [31:0] exp [1:9];
    always_comb begin
        act[1] = {31'd0, ihit};   act[2] = iload;   act[3] = {31'd0, dhit};   act[4] = dload;
        act[5] = {31'd0, ramREN}; act[6] = {31'd0, ramWEN}; act[7] = ramaddr; act[8] = ramstore;
        act[9] = {31'd0, err};
        exp[1] = {31'd0, own == 2 && iREN && ramstate == 2'd2};
        exp[2] = exp[1][0] ? ramload : 32'd0;
        exp[3] = {31'd0, own == 1 && m_dreq && ramstate == 2'd2};
        exp[4] = exp[3][0] ? ramload : 32'd0;
        exp[5] = {31'd0, (own == 1) ? (dREN && !dWEN) : (own == 2 && iREN)};
        exp[6] = {31'd0, own == 1 && dWEN};
        exp[7] = (own == 1) ? daddr : (own == 2) ? iaddr : 32'd0;
        exp[8] = (own == 1) ? dstore : 32'd0;
        exp[9] = {31'd0, m_err};
    end

    function automatic string nm(int i);
        case (i)
            1: return "ihit";   2: return "iload";  3: return "dhit";     4: return "dload";
            5: return "ramREN"; 6: return "ramWEN"; 7: return "ramaddr";  8: return "ramstore";
            default: return "err";
        endcase
    endfunction

    // Literal expectations written by the stimulus for the current cycle.
    logic [9:1]  pin_m;
    logic [31:0] pin_v [1:9];
    int n_cmp = 0, n_bad = 0;

    always @(negedge CLK) begin
        for (int i = 1; i <= 9; i++) begin
            n_cmp++;
            if (act[i] !== exp[i]) begin
                n_bad++;
                $display("FAIL model %s @%0t: got %h want %h", nm(i), $time, act[i], exp[i]);
            end
            if (pin_m[i]) begin
                n_cmp++;
                if (act[i] !== pin_v[i]) begin
                    n_bad++;
                    $display("FAIL pin %s @%0t: got %h want %h", nm(i), $time, act[i], pin_v[i]);
                end
            end
        end
    end

    task automatic step;
        @(posedge CLK);
        #1;
        pin_m = '0;
    endtask

    task automatic pin(input int i, input logic [31:0] v);
        pin_m[i] = 1'b1;
        pin_v[i] = v;
    endtask

    initial begin
        {iREN, dREN, dWEN} = '0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = 0;
        pin_m = '0; RST = 1'b1;
        step; step;
        RST = 1'b0;
        pin(1, 0); pin(3, 0); pin(5, 0); pin(6, 0); pin(9, 0);
        step;
        // single instruction read, ACCESS on the 2nd grant cycle
        iREN = 1; iaddr = 32'h40; pin(5, 0);
        step; ramstate = 1; pin(5, 1); pin(7, 32'h40); pin(1, 0);
        step; ramstate = 2; ramload = 32'hDEADBEEF; pin(1, 1); pin(2, 32'hDEADBEEF);
        step; iREN = 0; ramstate = 0; ramload = 0; pin(5, 0); pin(1, 0);
        step;
        // simultaneous instruction read and data write
        iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h80; dstore = 32'h1234; pin(6, 0);
        step; ramstate = 2; pin(6, 1); pin(5, 0); pin(7, 32'h80); pin(8, 32'h1234); pin(3, 1); pin(1, 0);
        step; dWEN = 0; ramstate = 0; pin(3, 0); pin(5, 0); pin(6, 0);
        step; ramstate = 2; ramload = 32'hCAFE0001; pin(1, 1); pin(2, 32'hCAFE0001); pin(7, 32'h44); pin(3, 0);
        step; iREN = 0; ramstate = 0; ramload = 0; pin(1, 0);
        step;
        // RAM error during a data read, then a good retry
        dREN = 1; daddr = 32'h90;
        step; ramstate = 3; pin(5, 1); pin(3, 0); pin(9, 0);
        step; ramstate = 0; pin(5, 0); pin(9, 1);
        step; ramstate = 2; ramload = 32'h55; pin(3, 1); pin(4, 32'h55); pin(9, 1);
        step; dREN = 0; ramstate = 0; ramload = 0; pin(9, 1);
        step;
        // timeout twice in a row: the wait count must restart from zero
        RST = 1;
        step; RST = 0; pin(9, 0); pin(5, 0);
        dREN = 1; daddr = 32'hA0; ramstate = 1;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < TMO; k++) begin
                step; pin(5, 1); pin(9, (r == 0) ? 32'd0 : 32'd1);
            end
            step; dREN = 0; pin(5, 0); pin(9, 1);
            step; dREN = (r == 0); pin(5, 0);
        end
        // asynchronous reset in the middle of a data write
        dWEN = 1; daddr = 32'hB0; dstore = 32'h7; pin(6, 0);
        step; pin(6, 1); pin(9, 1);
        step; RST = 1; pin(6, 0); pin(7, 0); pin(9, 0);
        step; RST = 0; ramstate = 2; pin(6, 0); pin(3, 0);
        step; pin(3, 1); pin(6, 1);
        step; dWEN = 0; ramstate = 0; pin(3, 0);
        step;
        // data held continuously with a pending instruction read
        dREN = 1; iREN = 1; daddr = 32'hC0; iaddr = 32'hC4; ramstate = 2; ramload = 32'h11;
        for (int c = 1; c <= 10; c++) begin
            step;
            if (c == 9) begin
`ifdef MEM_ARB_STARVE_EN
                pin(1, 1); pin(3, 0); pin(7, 32'hC4);
`else
                pin(3, 1); pin(1, 0); pin(7, 32'hC0);
`endif
            end else if (c % 2 == 1) begin
                pin(3, 1); pin(4, 32'h11); pin(1, 0);
            end else begin
`ifdef MEM_ARB_STARVE_EN
                if (c == 10) iREN = 0;
`endif
                pin(1, 0); pin(3, 0);
            end
        end
        step; {iREN, dREN, dWEN} = '0; ramstate = 0; ramload = 0;
        step; pin(5, 0); pin(1, 0); pin(3, 0);
        step;
        #6;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
